// File: rtl/display_pkg.sv
// display_pkg
//   Shared definitions for the multiplexed seven-segment display path.
//   Contents:
//     scan_state_t  - scan FSM state encoding
//     SEG_OFF       - bus pattern with every segment dark (active-low segments)
//     hex_to_seg    - nibble to 7-segment pattern (segment a = bit 0, dot = bit 7)
//     lowest_set    - {found, index} of the lowest set bit of an 8-bit mask
//     next_above    - {found, index} of the lowest set bit strictly above cur
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0: pat = 8'hC0;
            4'h1: pat = 8'hF9;
            4'h2: pat = 8'hA4;
            4'h3: pat = 8'hB0;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h92;
            4'h6: pat = 8'h82;
            4'h7: pat = 8'hF8;
            4'h8: pat = 8'h80;
            4'h9: pat = 8'h90;
            4'hA: pat = 8'h88;
            4'hB: pat = 8'h83;
            4'hC: pat = 8'hC6;
            4'hD: pat = 8'hA1;
            4'hE: pat = 8'h86;
            default: pat = 8'h8E;
        endcase
        return pat;
    endfunction

    // Scans downward so the last hit, i.e. the lowest index, wins.
    function automatic logic [3:0] lowest_set(input logic [7:0] mask);
        logic [3:0] res;
        res = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    function automatic logic [3:0] next_above(input logic [7:0] mask,
                                              input logic [2:0] cur);
        logic [3:0] res;
        res = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (3'(i) > cur)) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_digit_bank.sv
// seg_digit_bank
//   Dual-bank digit register file. Producers write the shadow bank; a commit
//   strobe copies the whole shadow bank into the active (displayed) bank in
//   one clock so a multi-digit update is never seen half-applied.
//   Ports:
//     clk, rst           clock, async active-high reset (both banks -> SEG_OFF)
//     wr_en              write strobe (already qualified by valid & ready)
//     wr_addr, wr_data   digit index and segment pattern; index >= NUM_DIGITS dropped
//     commit             copy shadow -> active at this clock edge
//     rd_addr, rd_data   displayed pattern for the selected digit
module seg_digit_bank
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data
);

    localparam logic [3:0] NUM_DIG = 4'(NUM_DIGITS);

    // Always eight entries so the 3-bit address indexes cleanly; entries at or
    // above NUM_DIGITS are never written and stay at SEG_OFF.
    logic [7:0] shadow [8];
    logic [7:0] active [8];

    logic in_range;
    assign in_range = ({1'b0, wr_addr} < NUM_DIG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= SEG_OFF;
                active[i] <= SEG_OFF;
            end
        end else begin
            if (wr_en && in_range) shadow[wr_addr] <= wr_data;
            if (commit) begin
                for (int i = 0; i < 8; i++) active[i] <= shadow[i];
            end
        end
    end

    // During the commit cycle the active bank is about to take the shadow
    // values, so the read forwards them; this keeps a one-cycle blank correct.
    assign rd_data = commit ? shadow[rd_addr] : active[rd_addr];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Scan scheduler for the shared 8-digit seven-segment bus. Cycles through
//   the enabled digits, blanking the bus before each one to suppress ghosting,
//   and commits the producer shadow bank at every frame start.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no digit enabled; bus dark, 138 decoder disabled
//   BLANK | target digit addressed, segments dark for BLANK_CYCLES
//   SHOW  | target digit driven with its active pattern for DWELL_CYCLES
//
//   Ports:
//     clk, rst             clock, async active-high reset
//     wr_valid/ready/addr/data  producer write port into the shadow bank
//     digit_en             per-digit enable mask, sampled at each digit advance
//     sel_addr             74HC138 digit address
//     seg_data             segment bus (registered)
//     dec_en               digit 138 enable, high while scanning
//     dot_en               dot-matrix 138 enable, tied low
//     frame_start          one-cycle pulse on the commit cycle
module seg_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] digit_en,
    output logic [2:0] sel_addr,
    output logic [7:0] seg_data,
    output logic       dec_en,
    output logic       dot_en,
    output logic       frame_start
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [7:0]       DIGIT_MASK = 8'((1 << NUM_DIGITS) - 1);

    scan_state_t       state;
    logic [2:0]        cur;
    logic [CNT_W-1:0]  cnt;

    logic [7:0] en_masked;
    logic [3:0] first_dig;
    logic [3:0] next_dig;
    logic [7:0] rd_data;

    assign en_masked = digit_en & DIGIT_MASK;
    assign first_dig = lowest_set(en_masked);
    assign next_dig  = next_above(en_masked, cur);
    assign dot_en    = 1'b0;

    // frame_start is high exactly during the commit cycle, so it doubles as
    // the bank commit strobe.
    seg_digit_bank #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_valid & wr_ready),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .commit  (frame_start),
        .rd_addr (cur),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur         <= 3'd0;
            cnt         <= '0;
            sel_addr    <= 3'd0;
            seg_data    <= SEG_OFF;
            dec_en      <= 1'b0;
            frame_start <= 1'b0;
            wr_ready    <= 1'b1;
        end else begin
            frame_start <= 1'b0;
            wr_ready    <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (first_dig[3]) begin
                        state       <= ST_BLANK;
                        cur         <= first_dig[2:0];
                        sel_addr    <= first_dig[2:0];
                        cnt         <= BLANK_LOAD;
                        dec_en      <= 1'b1;
                        seg_data    <= SEG_OFF;
                        frame_start <= 1'b1;
                        wr_ready    <= 1'b0;
                    end
                end
                ST_BLANK: begin
                    if (cnt == '0) begin
                        state    <= ST_SHOW;
                        cnt      <= DWELL_LOAD;
                        seg_data <= rd_data;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == '0) begin
                        seg_data <= SEG_OFF;
                        if (next_dig[3]) begin
                            state    <= ST_BLANK;
                            cur      <= next_dig[2:0];
                            sel_addr <= next_dig[2:0];
                            cnt      <= BLANK_LOAD;
                        end else if (first_dig[3]) begin
                            // wrap to the lowest enabled digit: a new frame
                            state       <= ST_BLANK;
                            cur         <= first_dig[2:0];
                            sel_addr    <= first_dig[2:0];
                            cnt         <= BLANK_LOAD;
                            frame_start <= 1'b1;
                            wr_ready    <= 1'b0;
                        end else begin
                            state    <= ST_IDLE;
                            cnt      <= '0;
                            dec_en   <= 1'b0;
                            sel_addr <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    dec_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
    import display_pkg::*;

    localparam int ND   = 4;
    localparam int DW   = 8;
    localparam int BL   = 2;
    localparam int SLOT = DW + BL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'd0;
    logic [7:0] digit_en = 8'd0;
    logic       wr_ready;
    logic [2:0] sel_addr;
    logic [7:0] seg_data;
    logic       dec_en;
    logic       dot_en;
    logic       frame_start;

    int checks = 0;
    int failures = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .digit_en    (digit_en),
        .sel_addr    (sel_addr),
        .seg_data    (seg_data),
        .dec_en      (dec_en),
        .dot_en      (dot_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    // The scan is described as a sequence of digit slots; m_pos is the clock
    // position inside the current slot (blank first, then dwell).
    bit         m_idle;
    int         m_dig;
    int         m_pos;
    bit         m_fs;
    logic [7:0] m_sh  [8];
    logic [7:0] m_act [8];
    logic [7:0] e_seg;
    logic [2:0] e_sel;
    logic       e_dec;
    logic       e_fs;
    logic       e_rdy;
    int         lo;
    int         nx;

    always @(negedge clk) begin
        if (rst) begin
            m_idle = 1'b1;
            m_dig  = 0;
            m_pos  = 0;
            m_fs   = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_sh[i]  = 8'hFF;
                m_act[i] = 8'hFF;
            end
        end
        if (m_idle) begin
            e_seg = 8'hFF;
            e_sel = 3'd0;
            e_dec = 1'b0;
            e_fs  = 1'b0;
        end else begin
            e_sel = 3'(m_dig);
            e_dec = 1'b1;
            e_seg = (m_pos < BL) ? 8'hFF : m_act[m_dig];
            e_fs  = m_fs && (m_pos == 0);
        end
        e_rdy = !e_fs;
        chk("model_seg_data", 32'(seg_data), 32'(e_seg));
        chk("model_sel_addr", 32'(sel_addr), 32'(e_sel));
        chk("model_dec_en", 32'(dec_en), 32'(e_dec));
        chk("model_frame_start", 32'(frame_start), 32'(e_fs));
        chk("model_wr_ready", 32'(wr_ready), 32'(e_rdy));
        chk("model_dot_en", 32'(dot_en), 32'd0);
        if (!rst) begin
            if (e_fs) begin
                for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
            end
            if (wr_valid && e_rdy && (int'(wr_addr) < ND)) m_sh[wr_addr] = wr_data;
            lo = -1;
            for (int i = ND - 1; i >= 0; i--) if (digit_en[i]) lo = i;
            if (m_idle) begin
                if (lo >= 0) begin
                    m_idle = 1'b0;
                    m_dig  = lo;
                    m_pos  = 0;
                    m_fs   = 1'b1;
                end
            end else if (m_pos < SLOT - 1) begin
                m_pos++;
            end else begin
                nx = -1;
                for (int i = ND - 1; i > m_dig; i--) if (digit_en[i]) nx = i;
                if (nx >= 0) begin
                    m_dig = nx;
                    m_pos = 0;
                    m_fs  = 1'b0;
                end else if (lo >= 0) begin
                    m_dig = lo;
                    m_pos = 0;
                    m_fs  = 1'b1;
                end else begin
                    m_idle = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [7:0] data);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        for (int k = 0; k < 20; k++) begin
            if (wr_ready) begin
                step(1);
                wr_valid = 1'b0;
                return;
            end
            step(1);
        end
        wr_valid = 1'b0;
        timeout_fail("write_accept");
    endtask

    // Advances at least one cycle, then up to the next frame_start.
    task automatic wait_next_fs(input int bound, output int cyc);
        step(1);
        cyc = 1;
        while (!frame_start && cyc < bound) begin
            step(1);
            cyc++;
        end
        if (!frame_start) timeout_fail("wait_frame_start");
    endtask

    int c;
    int sel1_cnt, fs_cnt, stalls, misaligned, idx;
    logic acc;

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset and idle hold
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_seg_data", 32'(seg_data), 32'hFF);
        chk("reset_dec_en", 32'(dec_en), 32'd0);
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_sel_addr", 32'(sel_addr), 32'd0);
        step(50);
        chk("idle_hold_dec_en", 32'(dec_en), 32'd0);
        chk("idle_hold_seg", 32'(seg_data), 32'hFF);
        digit_en = 8'h80;
        step(10);
        chk("en_above_range_ignored", 32'(dec_en), 32'd0);
        digit_en = 8'h00;

        // 2: two digits, frame timing
        do_write(3'd0, 8'hC0);
        do_write(3'd1, 8'hF9);
        digit_en = 8'h03;
        wait_next_fs(10, c);
        chk("first_fs_latency", 32'(c), 32'd1);
        chk("commit_stall", 32'(wr_ready), 32'd0);
        chk("fs_sel0", 32'(sel_addr), 32'd0);
        chk("fs_blank", 32'(seg_data), 32'hFF);
        step(2);
        chk("show_digit0", 32'(seg_data), 32'hC0);
        step(8);
        chk("blank_digit1_sel", 32'(sel_addr), 32'd1);
        chk("blank_digit1_seg", 32'(seg_data), 32'hFF);
        step(2);
        chk("show_digit1", 32'(seg_data), 32'hF9);

        // 3: write during digit 1 shows only after the next commit
        do_write(3'd0, 8'hA4);
        wait_next_fs(30, c);
        chk("frame_period_03", 32'(c + 13), 32'd20);
        step(2);
        chk("digit0_after_commit", 32'(seg_data), 32'hA4);

        // 4: digits 0 and 2
        digit_en = 8'h05;
        do_write(3'd2, 8'h92);
        wait_next_fs(40, c);
        chk("fs_after_en05", 32'(c), 32'd17);
        sel1_cnt = 0;
        fs_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (dec_en && sel_addr == 3'd1) sel1_cnt++;
            if (frame_start) fs_cnt++;
            if (k == 12) begin
                chk("show_digit2_sel", 32'(sel_addr), 32'd2);
                chk("show_digit2_seg", 32'(seg_data), 32'h92);
            end
        end
        chk("never_sel1", 32'(sel1_cnt), 32'd0);
        chk("fs_count_40cyc", 32'(fs_cnt), 32'd2);

        // 5: continuous writes, one stall per frame
        stalls = 0;
        misaligned = 0;
        fs_cnt = 0;
        idx = 0;
        wr_valid = 1'b1;
        wr_addr = 3'd0;
        wr_data = 8'h20;
        for (int k = 0; k < 60; k++) begin
            acc = wr_ready;
            if (!acc) begin
                stalls++;
                if (!frame_start) misaligned++;
            end
            if (frame_start) fs_cnt++;
            step(1);
            if (acc) begin
                idx++;
                wr_addr = 3'(idx);
                wr_data = 8'h20 + 8'(idx);
            end
        end
        wr_valid = 1'b0;
        chk("stall_count", 32'(stalls), 32'd3);
        chk("stall_fs_count", 32'(fs_cnt), 32'd3);
        chk("stall_misaligned", 32'(misaligned), 32'd0);
        chk("writes_accepted", 32'(idx), 32'd57);
        chk("end_on_fs", 32'(frame_start), 32'd1);
        step(2);
        chk("write_before_commit", 32'(seg_data), 32'h58);
        step(10);
        chk("burst_digit2_sel", 32'(sel_addr), 32'd2);
        chk("burst_digit2_seg", 32'(seg_data), 32'h52);

        // single enabled digit: commit every BLANK+DWELL
        digit_en = 8'h01;
        wait_next_fs(40, c);
        chk("fs_after_en01", 32'(c), 32'd8);
        wait_next_fs(40, c);
        chk("single_digit_period", 32'(c), 32'd10);

        // 6: asynchronous reset mid-SHOW
        step(4);
        chk("pre_reset_showing", 32'(seg_data), 32'h58);
        rst = 1'b1;
        #1;
        chk("async_reset_seg", 32'(seg_data), 32'hFF);
        chk("async_reset_dec_en", 32'(dec_en), 32'd0);
        chk("async_reset_wr_ready", 32'(wr_ready), 32'd1);
        step(2);
        rst = 1'b0;
        wait_next_fs(10, c);
        chk("post_reset_fs_latency", 32'(c), 32'd1);
        step(2);
        chk("writes_lost_after_reset", 32'(seg_data), 32'hFF);
        chk("post_reset_dec_en", 32'(dec_en), 32'd1);

        // disabling all digits returns to idle after the dwell
        digit_en = 8'h00;
        step(30);
        chk("idle_after_disable", 32'(dec_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Scan scheduler for the shared 8-digit seven-segment bus: one 8-bit segment bus plus the 3-bit 74HC138 digit-select address.
- Time-multiplexes up to NUM_DIGITS digit registers onto the bus, with a blanking gap between digits to suppress ghosting.
- Producers (IR decoder, counters, debug) write digit patterns through a valid/ready port into a shadow bank.
- The shadow bank is committed to the displayed bank only at frame boundaries, so a multi-digit update never tears.

Parameters:
- NUM_DIGITS, 8: digits scanned; addressable range 0..NUM_DIGITS-1; max 8.
- DWELL_CYCLES, 50000: clocks each digit is driven (1 ms at 50 MHz).
- BLANK_CYCLES, 500: clocks of blanking before each digit.
- SEG_OFF, 8'hFF: segment pattern driven while blanked or idle (all segments off).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  producer has a digit write.
- wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready.
- wr_addr  in  3  digit index to write.
- wr_data  in  8  raw segment pattern for that digit.
- digit_en  in  8  per-digit enable mask; bit i enables digit i. Sampled at each digit advance.
- sel_addr  out  3  138 address for the driven digit.
- seg_data  out  8  segment bus.
- dec_en  out  1  digit 138 enable; 1 while the scan is active.
- dot_en  out  1  dot-matrix 138 enable; constant 0.
- frame_start  out  1  one-cycle pulse on each commit cycle.

Behaviour:
- Interface:
  - One clock, clk.
  - rst is asynchronous, active-high.
  - All state is cleared on assertion of rst.
- Reset values:
  - sel_addr=0, seg_data=SEG_OFF, dec_en=0, dot_en=0, frame_start=0, wr_ready=1.
  - Shadow and active banks all SEG_OFF; FSM in IDLE; counter=0.
- FSM states: IDLE, BLANK, SHOW.
- IDLE:
  - seg_data=SEG_OFF, dec_en=0.
  - When digit_en has any bit set below NUM_DIGITS, go to BLANK on the lowest enabled digit as a frame start.
- BLANK:
  - sel_addr = target digit, seg_data=SEG_OFF, dec_en=1.
  - Lasts exactly BLANK_CYCLES clocks, then SHOW.
- SHOW:
  - seg_data = active[cur], lasts exactly DWELL_CYCLES clocks.
  - Then pick the next enabled digit above cur. If none, wrap to the lowest enabled digit; the wrap is a frame start.
  - Go to BLANK for that digit.
  - If digit_en has no enabled bit at this point, go to IDLE.
- Frame-start commit:
  - Occurs in the first BLANK cycle of a frame start.
  - active <= shadow for all digits; frame_start=1; wr_ready=0 for that single cycle.
- Writes:
  - A write is accepted when wr_valid & wr_ready; shadow[wr_addr] <= wr_data.
  - A write with wr_addr >= NUM_DIGITS is accepted and discarded.
  - The same address written twice before a commit keeps the last value.
  - A write accepted in the cycle just before a commit is included in that commit.
- Counter:
  - Single down-counter, width clog2(max(DWELL_CYCLES,BLANK_CYCLES)).
  - Loaded on every state entry; no wrap-around.
- digit_en changes:
  - Take effect only at the next digit advance.
  - A disabled current digit finishes its dwell.
- Single enabled digit: every advance is a frame start, so a commit happens every BLANK+DWELL cycles.
- rst mid-scan: outputs return to their reset values asynchronously. Pending shadow writes are lost.
- Outputs are registered; no combinational path from wr_* to seg_data.

Decomposition:
- Shared package (display_pkg):
  - FSM state encoding.
  - SEG_OFF.
  - The 7-segment hex patterns 0-F, so producers can convert nibbles.
- One sub-module, seg_digit_bank: dual-bank (shadow/active) register file with write port and commit strobe.
- The FSM and counter live in seg_scan_ctrl.

Test Plan (bench parameters DWELL_CYCLES=8, BLANK_CYCLES=2):
1. Reset, digit_en=8'h00, hold rst high 3 cycles then release -> seg_data=8'hFF, dec_en=0, wr_ready=1, state stays IDLE for 50 cycles.
2. Write addr0=8'hC0, addr1=8'hF9; then digit_en=8'h03 -> frame_start pulse with wr_ready=0 that cycle; sel_addr=0 blank for 2 cycles then seg_data=8'hC0 for 8; sel_addr=1 blank 2 then 8'hF9 for 8; frame period 20 cycles.
3. While digit 1 is showing, write addr0=8'hA4 -> digit 0 keeps 8'hC0 until the next frame_start; after it, digit 0 shows 8'hA4.
4. digit_en=8'h05 -> scan order 0,2,0,2; sel_addr never 1; frame period 20 cycles.
5. Hold wr_valid continuously with an incrementing address -> exactly one stall cycle per frame, aligned with frame_start; no write lost or duplicated; addr 7 with NUM_DIGITS=4 is discarded.
6. Assert rst in the middle of SHOW -> seg_data=8'hFF and dec_en=0 before the next clk edge; after release, the display shows SEG_OFF (prior writes lost).
